// File: rtl/pwr_ramp_sequencer.sv
// Thermometer power ramp (up, hold, down) across NUM_MODULES load enables, with a 32-bit MISR
// folding the registered dummy returns; all outputs registered, 1-cycle response, no backpressure.
module pwr_ramp_sequencer #(
   parameter int NUM_MODULES  = 32,
   parameter int DWELL_CYCLES = 100000000,
   parameter int HOLD_CYCLES  = 500000000
) (
   input  logic                   clk100m,
   input  logic                   rstn,
   input  logic                   start,
   input  logic                   abort,
   input  logic [NUM_MODULES-1:0] dummy_in,
   output logic [NUM_MODULES-1:0] pwr_en_out,
   output logic [5:0]             level,
   output logic [2:0]             phase,
   output logic                   busy,
   output logic                   done,
   output logic [31:0]            signature
);

   localparam int MAXC = (DWELL_CYCLES > HOLD_CYCLES) ? DWELL_CYCLES : HOLD_CYCLES;
   localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
   localparam logic [TW-1:0] DW_TC = TW'(DWELL_CYCLES - 1);
   localparam logic [TW-1:0] HD_TC = TW'(HOLD_CYCLES - 1);
   localparam logic [5:0]    NM    = 6'(NUM_MODULES);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      RAMP_UP   = 3'd1,
      HOLD      = 3'd2,
      RAMP_DOWN = 3'd3,
      DONE      = 3'd4
   } state_t;

   state_t                 r_state;
   logic [5:0]             r_level;
   logic [NUM_MODULES-1:0] r_pwr;
   logic [NUM_MODULES-1:0] r_cap;
   logic [TW-1:0]          r_timer;
   logic                   r_busy;
   logic                   r_done;
   logic [31:0]            r_sig;

   logic                   w_dwell_tc;
   logic                   w_hold_tc;
   logic                   w_fb;
   logic [31:0]            w_d;
   logic [31:0]            w_misr;

   function automatic logic [NUM_MODULES-1:0] therm(input logic [5:0] lv);
      logic [NUM_MODULES-1:0] v;
      v = '0;
      for (int i = 0; i < NUM_MODULES; i++) v[i] = (6'(i) < lv);
      return v;
   endfunction

   assign w_dwell_tc = (r_timer == DW_TC);
   assign w_hold_tc  = (r_timer == HD_TC);
   assign w_d        = 32'(r_cap);
   assign w_fb       = r_sig[31] ^ r_sig[21] ^ r_sig[1] ^ r_sig[0];
   assign w_misr     = {r_sig[30:0], w_fb} ^ w_d;

   always_ff @(posedge clk100m) begin
      if (!rstn) begin
         r_state <= IDLE;
         r_level <= 6'd0;
         r_pwr   <= '0;
         r_cap   <= '0;
         r_timer <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_sig   <= 32'hFFFF_FFFF;
      end else begin
         r_cap  <= dummy_in;
         r_done <= 1'b0;
         // Abort wins over everything and freezes the signature on the same edge.
         if (abort && r_state != IDLE) begin
            r_state <= IDLE;
            r_level <= 6'd0;
            r_pwr   <= '0;
            r_timer <= '0;
            r_busy  <= 1'b0;
         end else begin
            if (r_busy) r_sig <= w_misr;
            case (r_state)
               IDLE: begin
                  if (start && !abort) begin
                     r_state <= RAMP_UP;
                     r_level <= 6'd1;
                     r_pwr   <= therm(6'd1);
                     r_timer <= '0;
                     r_busy  <= 1'b1;
                     r_sig   <= 32'hFFFF_FFFF;
                  end
               end
               RAMP_UP: begin
                  if (w_dwell_tc) begin
                     r_timer <= '0;
                     if (r_level == NM) begin
                        r_state <= HOLD;
                     end else begin
                        r_level <= r_level + 6'd1;
                        r_pwr   <= therm(r_level + 6'd1);
                     end
                  end else begin
                     r_timer <= r_timer + 1'b1;
                  end
               end
               HOLD, RAMP_DOWN: begin
                  if ((r_state == HOLD) ? w_hold_tc : w_dwell_tc) begin
                     r_timer <= '0;
                     r_level <= r_level - 6'd1;
                     r_pwr   <= therm(r_level - 6'd1);
                     // Reaching level 0 completes the sequence on this edge.
                     if (r_level == 6'd1) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end else begin
                        r_state <= RAMP_DOWN;
                     end
                  end else begin
                     r_timer <= r_timer + 1'b1;
                  end
               end
               DONE:    r_state <= IDLE;
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign pwr_en_out = r_pwr;
   assign level      = r_level;
   assign phase      = r_state;
   assign busy       = r_busy;
   assign done       = r_done;
   assign signature  = r_sig;

endmodule

// File: tb/tb_pwr_ramp_sequencer.sv
// Bench for pwr_ramp_sequencer: the reference model derives phase/level from elapsed edges since start.
module tb_pwr_ramp_sequencer;
   localparam int N = 4, D = 4, H = 8;
   localparam int T_DONE = (2 * N - 1) * D + H;

   logic          clk100m = 1'b0;
   logic          rstn = 1'b0, start = 1'b0, abort = 1'b0;
   logic [N-1:0]  dummy_in = '0;
   logic [N-1:0]  pwr_en_out;
   logic [5:0]    level;
   logic [2:0]    phase;
   logic          busy, done;
   logic [31:0]   signature;

   int n_checks = 0, n_fail = 0;

   // reference model: active flag, edges since the start edge, signature, capture
   bit           m_active = 1'b0;
   int           m_t = 0;
   logic [31:0]  m_sig = 32'hFFFF_FFFF;
   logic [N-1:0] m_cap = '0;

   pwr_ramp_sequencer #(.NUM_MODULES(N), .DWELL_CYCLES(D), .HOLD_CYCLES(H)) dut (
      .clk100m(clk100m), .rstn(rstn), .start(start), .abort(abort), .dummy_in(dummy_in),
      .pwr_en_out(pwr_en_out), .level(level), .phase(phase), .busy(busy), .done(done),
      .signature(signature)
   );

   always #5 clk100m = ~clk100m;

   function automatic int m_phase();
      if (!m_active)        return 0;
      if (m_t < N * D)      return 1;
      if (m_t < N * D + H)  return 2;
      if (m_t < T_DONE)     return 3;
      return 4;
   endfunction

   function automatic int m_level();
      if (!m_active)        return 0;
      if (m_t < N * D)      return m_t / D + 1;
      if (m_t < N * D + H)  return N;
      if (m_t >= T_DONE)    return 0;
      return N - 1 - (m_t - N * D - H) / D;
   endfunction

   function automatic logic [31:0] misr(input logic [31:0] s, input logic [N-1:0] d);
      logic fb;
      fb = s[31] ^ s[21] ^ s[1] ^ s[0];
      return {s[30:0], fb} ^ {{(32 - N){1'b0}}, d};
   endfunction

   function automatic logic [46:0] expv();
      int ph, lv;
      logic [N-1:0] p;
      ph = m_phase();
      lv = m_level();
      p  = N'((1 << lv) - 1);
      return {p, 6'(lv), 3'(ph), (ph >= 1 && ph <= 3), (ph == 4), m_sig};
   endfunction

   function automatic logic [46:0] obsv();
      return {pwr_en_out, level, phase, busy, done, signature};
   endfunction

   task automatic model_edge(input bit st, input bit ab, input bit rn, input logic [N-1:0] dm);
      int ph_prev;
      ph_prev = m_phase();
      if (!rn) begin
         m_active = 1'b0;
         m_sig    = 32'hFFFF_FFFF;
         m_cap    = '0;
      end else begin
         if (ab && ph_prev != 0) begin
            m_active = 1'b0;
         end else begin
            if (ph_prev >= 1 && ph_prev <= 3) m_sig = misr(m_sig, m_cap);
            if (ph_prev == 0) begin
               if (st && !ab) begin
                  m_active = 1'b1;
                  m_t      = 0;
                  m_sig    = 32'hFFFF_FFFF;
               end
            end else begin
               m_t++;
               if (m_t > T_DONE) m_active = 1'b0;
            end
         end
         m_cap = dm;
      end
   endtask

   task automatic step();
      @(posedge clk100m);
      model_edge(start, abort, rstn, dummy_in);
      #1;
   endtask

   task automatic go_idle();
      start = 1'b0;
      abort = 1'b1;
      step();
      abort = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      dummy_in = N'($urandom);
      step();
      start = 1'b1;
      step();
      n_checks++;
      if ({pwr_en_out, level, phase, busy, done, signature} !== {4'b0, 6'd0, 3'd0, 1'b0, 1'b0, 32'hFFFF_FFFF}) begin
         n_fail++;
         $display("FAIL reset: got %h required %h", obsv(), {4'b0, 6'd0, 3'd0, 1'b0, 1'b0, 32'hFFFF_FFFF});
      end
      start = 1'b0;
      rstn = 1'b1;
      step();
      n_checks++;
      if (obsv() !== expv()) begin
         n_fail++;
         $display("FAIL reset_release: got %h required %h", obsv(), expv());
      end
   endtask

   task automatic test_full_seq();
      int         ce [10] = '{0, 4, 8, 12, 16, 24, 28, 32, 36, 37};
      int         cl [10] = '{1, 2, 3, 4, 4, 3, 2, 1, 0, 0};
      int         cp [10] = '{1, 1, 1, 1, 2, 3, 3, 3, 4, 0};
      logic [3:0] cw [10] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hF, 4'h7, 4'h3, 4'h1, 4'h0, 4'h0};
      int k = 0, dones = 0;
      go_idle();
      dummy_in = '0;
      start = 1'b1;
      for (int e = 0; e <= 40; e++) begin
         step();
         start = 1'b0;
         n_checks++;
         if (obsv() !== expv()) begin
            n_fail++;
            $display("FAIL full_seq model edge %0d: got %h required %h", e, obsv(), expv());
         end
         if (done === 1'b1) dones++;
         if (k < 10 && e == ce[k]) begin
            n_checks++;
            if ({pwr_en_out, level, phase, done} !== {cw[k], 6'(cl[k]), 3'(cp[k]), (cp[k] == 4)}) begin
               n_fail++;
               $display("FAIL full_seq table edge %0d: got pwr=%b lvl=%0d ph=%0d done=%b required pwr=%b lvl=%0d ph=%0d",
                        e, pwr_en_out, level, phase, done, cw[k], cl[k], cp[k]);
            end
            k++;
         end
      end
      n_checks++;
      if (dones !== 1) begin
         n_fail++;
         $display("FAIL full_seq done_count: got %0d required 1", dones);
      end
   endtask

   task automatic test_abort();
      logic [31:0] sig_exp;
      int dones = 0;
      go_idle();
      dummy_in = N'($urandom);
      start = 1'b1;
      for (int e = 0; e < 10; e++) begin
         step();
         start = 1'b0;
         dummy_in = N'($urandom);
      end
      sig_exp = m_sig;
      abort = 1'b1;
      start = 1'b1;
      step();
      abort = 1'b0;
      start = 1'b0;
      n_checks++;
      if ({phase, pwr_en_out, level, done, signature} !== {3'd0, 4'd0, 6'd0, 1'b0, sig_exp}) begin
         n_fail++;
         $display("FAIL abort: got ph=%0d pwr=%b lvl=%0d done=%b sig=%h required 0/0/0/0 sig=%h",
                  phase, pwr_en_out, level, done, signature, sig_exp);
      end
      for (int e = 0; e < 40; e++) begin
         step();
         if (done === 1'b1) dones++;
      end
      n_checks++;
      if (dones !== 0 || obsv() !== expv()) begin
         n_fail++;
         $display("FAIL abort_after: dones=%0d got %h required %h", dones, obsv(), expv());
      end
   endtask

   task automatic test_start_held();
      go_idle();
      dummy_in = '0;
      start = 1'b1;
      for (int e = 0; e <= 38; e++) begin
         step();
         n_checks++;
         if (obsv() !== expv()) begin
            n_fail++;
            $display("FAIL start_held model edge %0d: got %h required %h", e, obsv(), expv());
         end
      end
      n_checks++;
      if (level !== 6'd1 || phase !== 3'd1) begin
         n_fail++;
         $display("FAIL start_held restart: got lvl=%0d ph=%0d required lvl=1 ph=1", level, phase);
      end
      start = 1'b0;
   endtask

   task automatic test_misr();
      logic [31:0] sig_end;
      go_idle();
      dummy_in = 4'b0001;
      start = 1'b1;
      for (int e = 0; e <= 37; e++) begin
         step();
         start = 1'b0;
      end
      sig_end = m_sig;
      n_checks++;
      if (signature !== sig_end) begin
         n_fail++;
         $display("FAIL misr_final: got %h required %h", signature, sig_end);
      end
      for (int e = 0; e < 20; e++) begin
         step();
         n_checks++;
         if (signature !== sig_end) begin
            n_fail++;
            $display("FAIL misr_idle_stable cycle %0d: got %h required %h", e, signature, sig_end);
         end
      end
   endtask

   task automatic test_rst_mid();
      go_idle();
      dummy_in = N'($urandom);
      start = 1'b1;
      for (int e = 0; e < 20; e++) begin
         step();
         start = 1'b0;
      end
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      n_checks++;
      if ({level, phase, pwr_en_out, signature} !== {6'd0, 3'd0, 4'd0, 32'hFFFF_FFFF}) begin
         n_fail++;
         $display("FAIL rst_mid: got lvl=%0d ph=%0d pwr=%b sig=%h required 0/0/0/ffffffff",
                  level, phase, pwr_en_out, signature);
      end
      start = 1'b1;
      for (int e = 0; e <= 37; e++) begin
         step();
         start = 1'b0;
         n_checks++;
         if (obsv() !== expv()) begin
            n_fail++;
            $display("FAIL rst_mid rerun edge %0d: got %h required %h", e, obsv(), expv());
         end
         if (e == 16 || e == 36) begin
            n_checks++;
            if (phase !== ((e == 16) ? 3'd2 : 3'd4)) begin
               n_fail++;
               $display("FAIL rst_mid phase edge %0d: got %0d required %0d", e, phase, (e == 16) ? 2 : 4);
            end
         end
      end
   endtask

   task automatic test_random();
      go_idle();
      for (int c = 0; c < 800; c++) begin
         start    = ($urandom_range(0, 7) == 0);
         abort    = ($urandom_range(0, 149) == 0);
         rstn     = ($urandom_range(0, 299) != 0);
         dummy_in = N'($urandom);
         step();
         n_checks++;
         if (obsv() !== expv()) begin
            n_fail++;
            $display("FAIL random cycle %0d: got %h required %h", c, obsv(), expv());
         end
      end
      rstn  = 1'b1;
      start = 1'b0;
      abort = 1'b0;
   endtask

   initial begin
      test_reset();
      test_full_seq();
      test_abort();
      test_start_held();
      test_misr();
      test_rst_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
